// File: rtl/tile_frame_drawer_if.sv
// Signal bundle between the tile frame drawer, its two ROMs and the pixel sink.
// The master side is the drawer; the slave side is the surrounding system.
interface tile_frame_drawer_if #(
   parameter int NUM_DIGITS = 3
);
   logic                    start;
   logic [2:0]              image_sel;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [17:0]             img_addr;
   logic [23:0]             img_data;
   logic [11:0]             dig_addr;
   logic [23:0]             dig_data;
   logic [7:0]              x_out;
   logic [6:0]              y_out;
   logic [23:0]             colour_out;
   logic                    plot;
   logic                    busy;
   logic                    done;

   modport master (
      input  start, image_sel, digits, img_data, dig_data,
      output img_addr, dig_addr, x_out, y_out, colour_out, plot, busy, done
   );

   modport slave (
      output start, image_sel, digits, img_data, dig_data,
      input  img_addr, dig_addr, x_out, y_out, colour_out, plot, busy, done
   );
endinterface

// File: rtl/tile_frame_drawer.sv
// Draws one frame in raster order: a banner of digit tiles (score, right-aligned)
// followed by a background image, fetching pixels from two fixed-latency ROMs.
module tile_frame_drawer #(
   parameter int SCREEN_W   = 160,
   parameter int BANNER_H   = 20,
   parameter int BODY_H     = 100,
   parameter int TILE_W     = 20,
   parameter int NUM_DIGITS = 3,
   parameter int ROM_LAT    = 1
) (
   input logic               clk,
   input logic               resetn,
   tile_frame_drawer_if.master bus
);

   localparam int              NUM_TILES   = SCREEN_W / TILE_W;
   localparam logic [7:0]      X_LAST      = 8'(SCREEN_W - 1);
   localparam logic [6:0]      BANNER_LAST = 7'(BANNER_H - 1);
   localparam logic [6:0]      Y_LAST      = 7'(BANNER_H + BODY_H - 1);
   localparam logic [7:0]      TX_LAST     = 8'(TILE_W - 1);
   localparam logic [1:0]      FLUSH_LAST  = 2'(ROM_LAT - 1);
   localparam logic [11:0]     ROW_STEP    = 12'(TILE_W);
   localparam logic [11:0]     DIG_STRIDE  = 12'(TILE_W * BANNER_H);
   localparam logic [17:0]     IMG_STRIDE  = 18'(SCREEN_W * BODY_H);

   typedef enum logic [1:0] {IDLE, BANNER, BODY, FLUSH} state_t;
   typedef enum logic [1:0] {SRC_BLACK, SRC_DIG, SRC_IMG} src_t;

   state_t                  state_q, state_d;
   logic [7:0]              x_q, x_d;
   logic [6:0]              y_q, y_d;
   logic [7:0]              tile_q, tile_d;
   logic [7:0]              tx_q, tx_d;
   logic [11:0]             dig_row_q, dig_row_d;
   logic [17:0]             img_cnt_q, img_cnt_d;
   logic [1:0]              flush_q, flush_d;
   logic                    done_q, done_d;
   logic [2:0]              sel_q, sel_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;

   logic                    pipe_vld_q [ROM_LAT];
   logic                    pipe_vld_d [ROM_LAT];
   logic [7:0]              pipe_x_q   [ROM_LAT];
   logic [7:0]              pipe_x_d   [ROM_LAT];
   logic [6:0]              pipe_y_q   [ROM_LAT];
   logic [6:0]              pipe_y_d   [ROM_LAT];
   src_t                    pipe_src_q [ROM_LAT];
   src_t                    pipe_src_d [ROM_LAT];

   logic [7:0]              hold_x_q, hold_x_d;
   logic [6:0]              hold_y_q, hold_y_d;
   logic [23:0]             hold_colour_q, hold_colour_d;

   logic [3:0]              cur_digit;
   logic                    is_dig_tile;
   src_t                    cur_src;
   logic [17:0]             img_addr_w;
   logic [11:0]             dig_addr_w;
   logic                    plot_w;
   logic [23:0]             colour_w;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      tile_d    = tile_q;
      tx_d      = tx_q;
      dig_row_d = dig_row_q;
      img_cnt_d = img_cnt_q;
      flush_d   = flush_q;
      done_d    = 1'b0;
      sel_d     = sel_q;
      digits_d  = digits_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = BANNER;
               x_d       = '0;
               y_d       = '0;
               tile_d    = '0;
               tx_d      = '0;
               dig_row_d = '0;
               sel_d     = bus.image_sel;
               digits_d  = bus.digits;
            end
         end
         BANNER: begin
            if (x_q == X_LAST) begin
               x_d    = '0;
               tile_d = '0;
               tx_d   = '0;
               y_d    = y_q + 7'd1;
               if (y_q == BANNER_LAST) begin
                  state_d   = BODY;
                  img_cnt_d = 18'(sel_q) * IMG_STRIDE;
               end else begin
                  dig_row_d = dig_row_q + ROW_STEP;
               end
            end else begin
               x_d = x_q + 8'd1;
               if (tx_q == TX_LAST) begin
                  tx_d   = '0;
                  tile_d = tile_q + 8'd1;
               end else begin
                  tx_d = tx_q + 8'd1;
               end
            end
         end
         // The body is stored contiguously, so its address is a plain running count.
         BODY: begin
            img_cnt_d = img_cnt_q + 18'd1;
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  state_d = FLUSH;
                  flush_d = '0;
               end else begin
                  y_d = y_q + 7'd1;
               end
            end else begin
               x_d = x_q + 8'd1;
            end
         end
         FLUSH: begin
            if (flush_q == FLUSH_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               flush_d = flush_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_digit   = '0;
      is_dig_tile = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (tile_q == 8'(NUM_TILES - 1 - i)) begin
            cur_digit   = digits_q[4*i +: 4];
            is_dig_tile = 1'b1;
         end
      end
      cur_src    = SRC_BLACK;
      img_addr_w = '0;
      dig_addr_w = '0;
      if (state_q == BANNER) begin
         if (is_dig_tile && (cur_digit <= 4'd9)) begin
            cur_src    = SRC_DIG;
            dig_addr_w = 12'(cur_digit) * DIG_STRIDE + dig_row_q + 12'(tx_q);
         end
      end else if (state_q == BODY) begin
         cur_src    = SRC_IMG;
         img_addr_w = img_cnt_q;
      end
   end

   // Position and source travel alongside the ROM read so they meet its data.
   always_comb begin
      pipe_vld_d[0] = (state_q == BANNER) || (state_q == BODY);
      pipe_x_d[0]   = x_q;
      pipe_y_d[0]   = y_q;
      pipe_src_d[0] = cur_src;
      for (int i = 1; i < ROM_LAT; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_x_d[i]   = pipe_x_q[i-1];
         pipe_y_d[i]   = pipe_y_q[i-1];
         pipe_src_d[i] = pipe_src_q[i-1];
      end

      plot_w = pipe_vld_q[ROM_LAT-1];
      case (pipe_src_q[ROM_LAT-1])
         SRC_DIG: colour_w = bus.dig_data;
         SRC_IMG: colour_w = bus.img_data;
         default: colour_w = '0;
      endcase

      hold_x_d      = hold_x_q;
      hold_y_d      = hold_y_q;
      hold_colour_d = hold_colour_q;
      if (plot_w) begin
         hold_x_d      = pipe_x_q[ROM_LAT-1];
         hold_y_d      = pipe_y_q[ROM_LAT-1];
         hold_colour_d = colour_w;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         tile_q        <= '0;
         tx_q          <= '0;
         dig_row_q     <= '0;
         img_cnt_q     <= '0;
         flush_q       <= '0;
         done_q        <= 1'b0;
         sel_q         <= '0;
         digits_q      <= '0;
         hold_x_q      <= '0;
         hold_y_q      <= '0;
         hold_colour_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_x_q[i]   <= '0;
            pipe_y_q[i]   <= '0;
            pipe_src_q[i] <= SRC_BLACK;
         end
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         tile_q        <= tile_d;
         tx_q          <= tx_d;
         dig_row_q     <= dig_row_d;
         img_cnt_q     <= img_cnt_d;
         flush_q       <= flush_d;
         done_q        <= done_d;
         sel_q         <= sel_d;
         digits_q      <= digits_d;
         hold_x_q      <= hold_x_d;
         hold_y_q      <= hold_y_d;
         hold_colour_q <= hold_colour_d;
         pipe_vld_q    <= pipe_vld_d;
         pipe_x_q      <= pipe_x_d;
         pipe_y_q      <= pipe_y_d;
         pipe_src_q    <= pipe_src_d;
      end
   end

   assign bus.img_addr   = img_addr_w;
   assign bus.dig_addr   = dig_addr_w;
   assign bus.plot       = plot_w;
   assign bus.x_out      = plot_w ? pipe_x_q[ROM_LAT-1] : hold_x_q;
   assign bus.y_out      = plot_w ? pipe_y_q[ROM_LAT-1] : hold_y_q;
   assign bus.colour_out = plot_w ? colour_w : hold_colour_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;

endmodule

// File: tb/tb_tile_frame_drawer.sv
// Scoreboard bench for tile_frame_drawer: one instance with ROM_LAT=1 and one with
// ROM_LAT=3, each fed by a model ROM whose data encodes the address it was read from.
module tb_tile_frame_drawer;

   localparam int W         = 160;
   localparam int BH        = 20;
   localparam int FRAME_PIX = 19200;

   typedef struct packed {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [23:0] colour;
   } pix_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   pix_t        expQ0[$];
   pix_t        expQ1[$];
   int          frameCnt[2];
   int          issueCnt[2];
   int          lastIssueEdge[2];
   bit          pendingDone[2];
   bit          doneSeen[2];
   logic [2:0]  selL[2];
   logic [11:0] dgL[2];

   logic [23:0] img0Q, dig0Q;
   logic [23:0] img1P[3];
   logic [23:0] dig1P[3];

   tile_frame_drawer_if #(.NUM_DIGITS(3)) bus0();
   tile_frame_drawer_if #(.NUM_DIGITS(3)) bus1();

   tile_frame_drawer #(.ROM_LAT(1)) u0 (.clk(clk), .resetn(resetn), .bus(bus0));
   tile_frame_drawer #(.ROM_LAT(3)) u1 (.clk(clk), .resetn(resetn), .bus(bus1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Model ROMs: the data word carries a tag plus the address, so a wrong address shows.
   function automatic logic [23:0] imgRom(input logic [17:0] a);
      return {6'h2A, a};
   endfunction

   function automatic logic [23:0] digRom(input logic [11:0] a);
      return {12'hD16, a};
   endfunction

   always @(posedge clk) begin
      img0Q    <= imgRom(bus0.img_addr);
      dig0Q    <= digRom(bus0.dig_addr);
      img1P[0] <= imgRom(bus1.img_addr);
      img1P[1] <= img1P[0];
      img1P[2] <= img1P[1];
      dig1P[0] <= digRom(bus1.dig_addr);
      dig1P[1] <= dig1P[0];
      dig1P[2] <= dig1P[1];
   end

   assign bus0.img_data = img0Q;
   assign bus0.dig_data = dig0Q;
   assign bus1.img_data = img1P[2];
   assign bus1.dig_data = dig1P[2];

   // Expected addresses for raster index n: {img_addr, dig_addr}.
   function automatic logic [29:0] modelAddr(input int n, input logic [2:0] sel, input logic [11:0] dg);
      int x, y, t, d;
      logic [17:0] ia;
      logic [11:0] da;
      x  = n % W;
      y  = n / W;
      ia = '0;
      da = '0;
      if (y < BH) begin
         t = x / 20;
         if (t >= 5) begin
            d = int'(dg[4*(7-t) +: 4]);
            if (d <= 9) da = 12'(d*400 + y*20 + x%20);
         end
      end else begin
         ia = 18'(int'(sel)*16000 + (y-BH)*W + x);
      end
      return {ia, da};
   endfunction

   function automatic pix_t modelPixel(input int n, input logic [2:0] sel, input logic [11:0] dg);
      pix_t p;
      logic [29:0] a;
      int y;
      y        = n / W;
      a        = modelAddr(n, sel, dg);
      p.x      = 8'(n % W);
      p.y      = 7'(y);
      p.colour = '0;
      if (y >= BH) p.colour = imgRom(a[29:12]);
      else if (a[11:0] != 12'd0 || (n % W) >= 100) begin
         if (int'(dg[4*(7-(n%W)/20) +: 4]) <= 9) p.colour = digRom(a[11:0]);
      end
      return p;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int k, input logic [2:0] sel, input logic [11:0] dg);
      selL[k]     = sel;
      dgL[k]      = dg;
      doneSeen[k] = 1'b0;
      for (int n = 0; n < FRAME_PIX; n++) begin
         if (k == 0) expQ0.push_back(modelPixel(n, sel, dg));
         else        expQ1.push_back(modelPixel(n, sel, dg));
      end
      if (k == 0) begin
         bus0.image_sel = sel;
         bus0.digits    = dg;
         bus0.start     = 1'b1;
      end else begin
         bus1.image_sel = sel;
         bus1.digits    = dg;
         bus1.start     = 1'b1;
      end
   endtask

   task automatic waitDone(input int k, input int limit);
      int n = 0;
      while (!doneSeen[k] && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!doneSeen[k]) begin
         checks++;
         errors++;
         $display("[TB] FAIL u%0d done timeout actual=none required=pulse within %0d cycles", k, limit);
      end
   endtask

   task automatic monitorStep(input int k, input logic plot, input logic busy, input logic done,
                              input logic [7:0] x, input logic [6:0] y, input logic [23:0] colour,
                              input logic [17:0] ia, input logic [11:0] da);
      pix_t        e;
      logic [29:0] ea;
      int          n;
      if (!resetn) begin
         frameCnt[k]    = 0;
         issueCnt[k]    = 0;
         pendingDone[k] = 1'b0;
         return;
      end
      if (pendingDone[k] || done) begin
         checkOutput($sformatf("u%0d done pulse", k), 32'(done), 32'(pendingDone[k]));
         if (done) begin
            checkOutput($sformatf("u%0d busy during done", k), 32'(busy), 0);
            checkOutput($sformatf("u%0d plot count", k), frameCnt[k], FRAME_PIX);
            checkOutput($sformatf("u%0d held x_out", k), 32'(x), 159);
            checkOutput($sformatf("u%0d held y_out", k), 32'(y), 119);
            // ROM_LAT cycles after the edge that hands the last address to the ROM.
            checkOutput($sformatf("u%0d done latency", k), cyc - lastIssueEdge[k], (k == 0) ? 1 : 3);
            frameCnt[k] = 0;
            issueCnt[k] = 0;
            doneSeen[k] = 1'b1;
         end
         pendingDone[k] = 1'b0;
      end
      if (busy && issueCnt[k] < FRAME_PIX) begin
         n  = issueCnt[k];
         ea = modelAddr(n, selL[k], dgL[k]);
         checkOutput($sformatf("u%0d img_addr n=%0d", k, n), 32'(ia), 32'(ea[29:12]));
         checkOutput($sformatf("u%0d dig_addr n=%0d", k, n), 32'(da), 32'(ea[11:0]));
         if (k == 0 && selL[0] == 3'd2 && dgL[0] == 12'h123) begin
            if (n == 20*W + 5)   checkOutput("img_addr (5,20)", 32'(ia), 32005);
            if (n == FRAME_PIX-1) checkOutput("img_addr (159,119)", 32'(ia), 47999);
            if (n == 140)        checkOutput("dig_addr (140,0)", 32'(da), 1200);
            if (n == 19*W + 159) checkOutput("dig_addr (159,19)", 32'(da), 1599);
            if (n == 100)        checkOutput("dig_addr (100,0)", 32'(da), 400);
         end
         if (k == 0 && dgL[0] == 12'hA00 && n == 100) checkOutput("dig_addr digit A", 32'(da), 0);
         if (n == FRAME_PIX-1) lastIssueEdge[k] = cyc + 1;
         issueCnt[k]++;
      end
      if (plot) begin
         checkOutput($sformatf("u%0d busy with plot", k), 32'(busy), 1);
         if ((k == 0 && expQ0.size() == 0) || (k == 1 && expQ1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL u%0d unexpected plot actual=(%0d,%0d) required=no plot", k, x, y);
         end else begin
            e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput($sformatf("u%0d x_out #%0d", k, frameCnt[k]), 32'(x), 32'(e.x));
            checkOutput($sformatf("u%0d y_out #%0d", k, frameCnt[k]), 32'(y), 32'(e.y));
            checkOutput($sformatf("u%0d colour #%0d", k, frameCnt[k]), 32'(colour), 32'(e.colour));
         end
         frameCnt[k]++;
         if (frameCnt[k] == FRAME_PIX) pendingDone[k] = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      monitorStep(0, bus0.plot, bus0.busy, bus0.done, bus0.x_out, bus0.y_out,
                  bus0.colour_out, bus0.img_addr, bus0.dig_addr);
      monitorStep(1, bus1.plot, bus1.busy, bus1.done, bus1.x_out, bus1.y_out,
                  bus1.colour_out, bus1.img_addr, bus1.dig_addr);
   end

   initial begin
      int n;
      resetn         = 1'b0;
      bus0.start     = 1'b0;
      bus0.image_sel = '0;
      bus0.digits    = '0;
      bus1.start     = 1'b0;
      bus1.image_sel = '0;
      bus1.digits    = '0;
      for (int k = 0; k < 2; k++) begin
         frameCnt[k]      = 0;
         issueCnt[k]      = 0;
         lastIssueEdge[k] = 0;
         pendingDone[k]   = 1'b0;
         doneSeen[k]      = 1'b0;
         selL[k]          = '0;
         dgL[k]           = '0;
      end
      repeat (3) @(negedge clk);
      checkOutput("reset plot", 32'(bus0.plot), 0);
      checkOutput("reset busy", 32'(bus0.busy), 0);
      checkOutput("reset done", 32'(bus0.done), 0);
      checkOutput("reset x_out", 32'(bus0.x_out), 0);
      checkOutput("reset y_out", 32'(bus0.y_out), 0);
      checkOutput("reset colour_out", 32'(bus0.colour_out), 0);
      checkOutput("reset img_addr", 32'(bus0.img_addr), 0);
      checkOutput("reset dig_addr", 32'(bus0.dig_addr), 0);
      resetn = 1'b1;
      @(negedge clk);

      $display("[TB] frame 1: image 2, digits 123, re-pulse mid-frame; ROM_LAT=3 frame alongside");
      applyStimulus(0, 3'd2, 12'h123);
      applyStimulus(1, 3'd5, 12'h456);
      @(negedge clk);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      repeat (300) @(negedge clk);
      bus0.digits    = 12'h999;
      bus0.image_sel = 3'd7;
      bus0.start     = 1'b1;
      repeat (3) @(negedge clk);
      bus0.start = 1'b0;
      waitDone(0, 25000);
      waitDone(1, 25000);

      $display("[TB] frame 2: digits A00, tile 5 black");
      @(negedge clk);
      applyStimulus(0, 3'd4, 12'hA00);
      @(negedge clk);
      bus0.start = 1'b0;
      waitDone(0, 25000);

      $display("[TB] frame 3: reset at plot 5000");
      @(negedge clk);
      applyStimulus(0, 3'd1, 12'h042);
      @(negedge clk);
      bus0.start = 1'b0;
      n = 0;
      while (frameCnt[0] < 5000 && n < 6000) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("plots before abort", frameCnt[0], 5000);
      resetn = 1'b0;
      @(negedge clk);
      checkOutput("abort plot", 32'(bus0.plot), 0);
      checkOutput("abort busy", 32'(bus0.busy), 0);
      checkOutput("abort x_out", 32'(bus0.x_out), 0);
      checkOutput("abort y_out", 32'(bus0.y_out), 0);
      expQ0.delete();
      @(negedge clk);
      checkOutput("abort plot held low", 32'(bus0.plot), 0);
      resetn = 1'b1;
      @(negedge clk);

      $display("[TB] frame 4: full frame after abort");
      applyStimulus(0, 3'd3, 12'h789);
      @(negedge clk);
      bus0.start = 1'b0;
      waitDone(0, 25000);

      repeat (4) @(negedge clk);
      checkOutput("u0 scoreboard drained", expQ0.size(), 0);
      checkOutput("u1 scoreboard drained", expQ1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_frame_drawer.md
TILE_FRAME_DRAWER -- requirements
Module: tile_frame_drawer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, pixels per row.
REQ-002 SHALL have parameter BANNER_H, default 20, banner rows; also the digit tile height.
REQ-003 SHALL have parameter BODY_H, default 100, image rows below the banner.
REQ-004 SHALL have parameter TILE_W, default 20, digit tile width; SCREEN_W is a multiple of TILE_W.
REQ-005 SHALL have parameter NUM_DIGITS, default 3, score digits; NUM_DIGITS <= SCREEN_W/TILE_W.
REQ-006 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles; legal range 1..4.
REQ-007 SHALL have port clk, input, 1, the only clock.
REQ-008 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-009 SHALL have port start, input, 1, frame request, sampled every clk.
REQ-010 SHALL have port image_sel, input, 3, body image index.
REQ-011 SHALL have port digits, input, 4*NUM_DIGITS, BCD digits; digit 0 is in [3:0] and is drawn rightmost.
REQ-012 SHALL have port img_addr, output, 18, background ROM address.
REQ-013 SHALL have port img_data, input, 24, background ROM data, valid ROM_LAT cycles after img_addr.
REQ-014 SHALL have port dig_addr, output, 12, digit ROM address.
REQ-015 SHALL have port dig_data, input, 24, digit ROM data, valid ROM_LAT cycles after dig_addr.
REQ-016 SHALL have ports x_out (output, 8), y_out (output, 7), colour_out (output, 24) and plot (output, 1).
REQ-017 SHALL have ports busy (output, 1) and done (output, 1, single-cycle pulse).

Function
REQ-018 SHALL implement states IDLE, BANNER, BODY and FLUSH.
REQ-019 SHALL accept start only in IDLE, or in the cycle done is high; accepting start latches image_sel and digits and enters BANNER with x=0, y=0.
REQ-020 SHALL ignore start while busy; latched values SHALL NOT change mid-frame.
REQ-021 SHALL generate one address per cycle, raster order, x 0..SCREEN_W-1 inner, y 0..BANNER_H+BODY_H-1 outer.
REQ-022 SHALL, in BANNER, compute tile t = x/TILE_W. Tiles t >= SCREEN_W/TILE_W - NUM_DIGITS show digit i = SCREEN_W/TILE_W-1-t; all other tiles show black.
REQ-023 SHALL, for a digit pixel, set dig_addr = d*TILE_W*BANNER_H + y*TILE_W + (x mod TILE_W), where d is the latched digit value.
REQ-024 SHALL drive black for digit values above 9, with dig_addr = 0.
REQ-025 SHALL move from BANNER to BODY after pixel (SCREEN_W-1, BANNER_H-1).
REQ-026 SHALL, in BODY, set img_addr = image_sel*SCREEN_W*BODY_H + (y-BANNER_H)*SCREEN_W + x.
REQ-027 SHALL delay x, y and the source select (black / digit / image) through a ROM_LAT-stage pipeline, so that x_out, y_out and colour_out are asserted together with plot=1.
REQ-028 SHALL plot exactly SCREEN_W*(BANNER_H+BODY_H) pixels per frame; plot=1 only for those pixels.
REQ-029 SHALL enter FLUSH after the last address is issued, stay ROM_LAT cycles, then pulse done for 1 cycle in the cycle after the last plot and return to IDLE.
REQ-030 SHALL hold busy=1 from the cycle after start is accepted until the last plot, inclusive; busy=0 while done=1.
REQ-031 SHALL hold x_out, y_out and colour_out at their last values when plot=0.

Reset
REQ-032 SHALL, when resetn=0 at a clk edge, go to IDLE, clear the pipeline, and drive plot, busy, done, x_out, y_out, colour_out, img_addr and dig_addr to 0 from the next cycle.
REQ-033 SHALL abort a frame on reset mid-frame with no further plot; the next start draws a complete frame.

Verification
REQ-034 SHALL cover: reset, then start with image_sel=2 and digits=0x123 -> exactly 19200 plots; first plot at (0,0) colour 0; last at (159,119); done 1 cycle after the last plot.
REQ-035 SHALL cover: same frame -> img_addr 32005 for pixel (5,20) and 47999 for (159,119); colour_out equals img_data returned ROM_LAT cycles earlier.
REQ-036 SHALL cover: same frame -> dig_addr 1200 at (140,0), 1599 at (159,19), 400 at (100,0); x 0..99 in the banner plot colour 0.
REQ-037 SHALL cover: start re-pulsed and digits changed to 0x999 mid-frame -> no restart, banner unchanged, plot count still 19200; digits=0xA00 on the next frame -> tile 5 black.
REQ-038 SHALL cover: resetn low at the 5000th plot -> next cycle plot=0, busy=0, x_out=y_out=0; a subsequent start gives a full 19200-pixel frame.
REQ-039 SHALL cover: ROM_LAT=3 with a model ROM -> every colour_out matches its (x_out, y_out) address; done 3 cycles after the last address is issued.
